// File: rtl/tick_counter_pkg.sv
// ============================================================================
// Module   : tick_counter_pkg
// Purpose  : Shared direction constants and prescaler width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tick_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // A prescaler for P_TICK=1 still needs one (constant-zero) bit.
  function automatic int pre_width(input int p_tick);
    int w;
    w = $clog2(p_tick);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_prescaler.sv
// ============================================================================
// Module   : m_prescaler
// Purpose  : Divides enabled clock cycles into a step pulse every P_TICK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module m_prescaler
  import tick_counter_pkg::*;
#(
  parameter int P_TICK = 100000000
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic w_en,
  input  logic w_clr,
  output logic w_step
);

  localparam int              PRE_W    = pre_width(P_TICK);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P_TICK - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] r_pre;

  assign w_step = w_en && (r_pre == PRE_LAST);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pre <= '0;
    end else if (w_clr) begin
      r_pre <= '0;
    end else if (w_step) begin
      r_pre <= '0;
    end else if (w_en) begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/m_tick_counter.sv
// ============================================================================
// Module   : m_tick_counter
// Purpose  : Prescaled up/down counter with clear, load and tick/wrap strobes.
//            Define TICK_COUNTER_SATURATE_EN to saturate instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module m_tick_counter
  import tick_counter_pkg::*;
#(
  parameter int P_WIDTH = 4,
  parameter int P_TICK  = 100000000,
  parameter int P_MAX   = 2**P_WIDTH - 1
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_en,
  input  logic               w_dir,
  input  logic               w_clr,
  input  logic               w_load,
  input  logic [P_WIDTH-1:0] w_load_val,
  output logic [P_WIDTH-1:0] w_cnt,
  output logic               w_tick,
  output logic               w_wrap
);

  localparam logic [P_WIDTH-1:0] MAX_V = P_WIDTH'(P_MAX);
  localparam logic [P_WIDTH-1:0] ONE_V = P_WIDTH'(1);

  logic               step;
  logic               at_bound;
  logic [P_WIDTH-1:0] next_cnt;
  logic [P_WIDTH-1:0] load_cnt;

  m_prescaler #(
    .P_TICK (P_TICK)
  ) u_prescaler (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_en    (w_en),
    .w_clr   (w_clr),
    .w_step  (step)
  );

  // Bound is checked before any arithmetic so the count never leaves 0..P_MAX.
  always_comb begin
    at_bound = (w_dir == DIR_UP) ? (w_cnt == MAX_V) : (w_cnt == '0);
    next_cnt = w_cnt;
    if (at_bound) begin
`ifdef TICK_COUNTER_SATURATE_EN
      next_cnt = w_cnt;
`else
      next_cnt = (w_dir == DIR_UP) ? '0 : MAX_V;
`endif
    end else if (w_dir == DIR_UP) begin
      next_cnt = w_cnt + ONE_V;
    end else begin
      next_cnt = w_cnt - ONE_V;
    end
    load_cnt = (w_load_val > MAX_V) ? MAX_V : w_load_val;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_cnt  <= '0;
      w_tick <= 1'b0;
      w_wrap <= 1'b0;
    end else begin
      w_tick <= 1'b0;
      w_wrap <= 1'b0;
      if (w_clr) begin
        w_cnt <= '0;
      end else if (w_load) begin
        w_cnt <= load_cnt;
      end else if (step) begin
        w_cnt  <= next_cnt;
        w_tick <= 1'b1;
        w_wrap <= at_bound;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_tick_counter.sv
// ============================================================================
// Module   : tb_m_tick_counter
// Purpose  : Vector table, directed sequences and random run against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_m_tick_counter;

  localparam int W    = 4;
  localparam int TICK = 4;
  localparam int MAXC = 9;
`ifdef TICK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] cnt;
  logic         tick;
  logic         wrap;

  int checks = 0;
  int passes = 0;

  // Reference model: count value plus total enabled cycles since last clear.
  int m_cnt = 0;
  int m_tot = 0;
  int m_tick = 0;
  int m_wrap = 0;

  typedef struct {
    bit en, dir, clr, load;
    int lv;
    int e_cnt, e_tick, e_wrap;
  } vec_t;
  vec_t vecs[$];

  m_tick_counter #(
    .P_WIDTH (W),
    .P_TICK  (TICK),
    .P_MAX   (MAXC)
  ) dut (
    .w_clk      (clk),
    .w_rst_n    (rst_n),
    .w_en       (en),
    .w_dir      (dir),
    .w_clr      (clr),
    .w_load     (load),
    .w_load_val (load_val),
    .w_cnt      (cnt),
    .w_tick     (tick),
    .w_wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tot = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit e, input bit d, input bit c, input bit l, input int lv);
    bit stp;
    stp = e && (((m_tot + 1) % TICK) == 0);
    m_tick = 0;
    m_wrap = 0;
    if (c) begin
      m_cnt = 0;
      m_tot = 0;
    end else begin
      if (e) m_tot++;
      if (l) begin
        m_cnt = (lv > MAXC) ? MAXC : lv;
      end else if (stp) begin
        m_tick = 1;
        if (!d) begin
          if (m_cnt == MAXC) begin m_wrap = 1; m_cnt = SAT ? MAXC : 0; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_wrap = 1; m_cnt = SAT ? 0 : MAXC; end
          else m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic apply(input bit e, input bit d, input bit c, input bit l, input int lv);
    en = e; dir = d; clr = c; load = l; load_val = W'(lv);
    @(posedge clk);
    model_edge(e, d, c, l, lv);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt"}, int'(cnt), m_cnt);
    chk({tag, "_tick"}, int'(tick), m_tick);
    chk({tag, "_wrap"}, int'(wrap), m_wrap);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; dir = 0; clr = 0; load = 0; load_val = '0;
    @(posedge clk); #1;
    model_reset();
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_wrap", int'(wrap), 0);
    rst_n = 1;
  endtask

  task automatic add_vec(input bit e, input bit d, input bit c, input bit l, input int lv,
                         input int ec, input int et, input int ew);
    vec_t v;
    v.en = e; v.dir = d; v.clr = c; v.load = l; v.lv = lv;
    v.e_cnt = ec; v.e_tick = et; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  initial begin
    // en dir clr load lv | cnt tick wrap
    add_vec(1, 0, 0, 0, 0,    0, 0, 0);
    add_vec(1, 0, 0, 0, 0,    0, 0, 0);
    add_vec(1, 0, 0, 0, 0,    0, 0, 0);
    add_vec(1, 0, 0, 0, 0,    1, 1, 0);   // first step on 4th edge
    add_vec(1, 0, 0, 0, 0,    1, 0, 0);
    add_vec(0, 0, 0, 0, 0,    1, 0, 0);
    add_vec(0, 0, 0, 0, 0,    1, 0, 0);
    add_vec(1, 0, 0, 0, 0,    1, 0, 0);
    add_vec(1, 0, 0, 0, 0,    1, 0, 0);
    add_vec(0, 0, 0, 0, 0,    1, 0, 0);   // disabled at the step cycle
    add_vec(1, 0, 0, 0, 0,    2, 1, 0);
    add_vec(1, 0, 0, 1, 13,   9, 0, 0);   // load clamps to 9
    add_vec(1, 0, 0, 0, 0,    9, 0, 0);
    add_vec(1, 0, 0, 0, 0,    9, 0, 0);
    add_vec(1, 0, 0, 1, 3,    3, 0, 0);   // load beats coincident step
    add_vec(1, 0, 0, 0, 0,    3, 0, 0);
    add_vec(1, 0, 0, 0, 0,    3, 0, 0);
    add_vec(1, 0, 0, 0, 0,    3, 0, 0);
    add_vec(1, 1, 0, 0, 0,    2, 1, 0);
    add_vec(1, 0, 1, 1, 7,    0, 0, 0);   // clear beats load
    add_vec(1, 1, 0, 0, 0,    0, 0, 0);
    add_vec(1, 1, 0, 0, 0,    0, 0, 0);
    add_vec(1, 1, 0, 0, 0,    0, 0, 0);
    add_vec(1, 1, 0, 0, 0,    SAT ? 0 : 9, 1, 1);
    add_vec(1, 0, 0, 0, 0,    SAT ? 0 : 9, 0, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].dir, vecs[i].clr, vecs[i].load, vecs[i].lv);
      chk($sformatf("vec%0d_cnt", i), int'(cnt), vecs[i].e_cnt);
      chk($sformatf("vec%0d_tick", i), int'(tick), vecs[i].e_tick);
      chk($sformatf("vec%0d_wrap", i), int'(wrap), vecs[i].e_wrap);
    end

    // Free-running up count from reset.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      int ec;
      apply(1, 0, 0, 0, 0);
      ec = SAT ? (((k / TICK) > MAXC) ? MAXC : (k / TICK)) : ((k / TICK) % (MAXC + 1));
      chk($sformatf("up%0d_cnt", k), int'(cnt), ec);
      chk($sformatf("up%0d_tick", k), int'(tick), int'((k % TICK) == 0));
      chk($sformatf("up%0d_wrap", k), int'(wrap), int'(k == 40));
    end
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 0, 0, 0);
      check_model("up_tail");
    end

    // Asynchronous reset in the middle of a cycle with a strobe pending.
    #2 rst_n = 0;
    #1;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      bit e, c, l;
      int lv;
      e  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      c  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 29) == 0);
      lv = $urandom_range(0, 15);
      apply(e, dir, c, l, lv);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
